// File: rtl/unified_mem_arbiter_pkg.sv
// mem_arb_pkg: shared states, grant encoding and default widths of the unified memory arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;
  typedef enum logic [2:0] {IDLE, I_WAIT, D_WAIT, I_DONE, D_DONE} state_t;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch/data requester, memory-port and status signals of the arbiter
interface unified_mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              if_re;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;
  logic              dm_re;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              err;
  modport master (
    input  if_re, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_stall, dm_rdata, dm_stall, mem_req, mem_we, mem_addr, mem_wdata, err
  );
  modport slave (
    output if_re, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_stall, dm_rdata, dm_stall, mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/unified_mem_arbiter_timeout_ctr.sv
// mem_arb_timeout_ctr: handshake watchdog, loadable wait counter with sticky err (TIMEOUT=0 disables)
module mem_arb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic err
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] cnt;
  // count wait cycles up to TIMEOUT and flag reaching it; err survives until reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && TIMEOUT != 0 && cnt != W'(TIMEOUT)) begin
      cnt <= cnt + 1'b1;
      err <= err | (cnt == W'(TIMEOUT - 1));
    end
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: IF/MEM sharing of one variable-latency memory; UNIFIED_MEM_ARB_PERF_EN adds stall counters
module unified_mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  unified_mem_arbiter_if.master bus
`ifdef UNIFIED_MEM_ARB_PERF_EN
  ,
  output logic [15:0] if_stall_cnt,
  output logic [15:0] dm_stall_cnt
`endif
);
  state_t            state, state_nxt;
  logic              last_grant, ireq, dreq, gnt_i, gnt_d, in_wait, err;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  assign ireq      = bus.if_re;
  assign dreq      = bus.dm_re | bus.dm_we;
  assign in_wait   = state == I_WAIT || state == D_WAIT;
  assign gnt_d     = state == IDLE && dreq && (!ireq || last_grant != GNT_D);
  assign gnt_i     = state == IDLE && ireq && !gnt_d;
  assign addr_sel  = gnt_d ? bus.dm_addr : bus.if_addr;
  assign wdata_sel = gnt_d ? bus.dm_wdata : '0;
  assign bus.if_stall = ireq && state != I_DONE;
  assign bus.dm_stall = dreq && state != D_DONE;
  assign bus.err      = err;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  // arbitration in IDLE, ack wait, one-cycle DONE; a withdrawn requester skips DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = gnt_d ? D_WAIT : gnt_i ? I_WAIT : IDLE;
      I_WAIT:  state_nxt = !bus.mem_ack ? I_WAIT : ireq ? I_DONE : IDLE;
      D_WAIT:  state_nxt = !bus.mem_ack ? D_WAIT : dreq ? D_DONE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // latch the granted request onto the memory port and capture read data on ack
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
      last_grant    <= GNT_I;
    end else if (gnt_i || gnt_d) begin
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= gnt_d && bus.dm_we;
      bus.mem_addr  <= addr_sel;
      bus.mem_wdata <= wdata_sel;
      last_grant    <= gnt_d ? GNT_D : GNT_I;
    end else if (in_wait && bus.mem_ack) begin
      bus.mem_req <= 1'b0;
      if (state_nxt == I_DONE) bus.if_rdata <= bus.mem_rdata;
      if (state_nxt == D_DONE) bus.dm_rdata <= bus.mem_rdata;
    end
  mem_arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk (clk),
    .rst (rst),
    .clr (gnt_i || gnt_d),
    .en  (in_wait),
    .err (err)
  );
`ifdef UNIFIED_MEM_ARB_PERF_EN
  // per-requester stall cycle counters, saturating at all ones
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      if_stall_cnt <= '0;
      dm_stall_cnt <= '0;
    end else begin
      if_stall_cnt <= if_stall_cnt + 16'(bus.if_stall && !(&if_stall_cnt));
      dm_stall_cnt <= dm_stall_cnt + 16'(bus.dm_stall && !(&dm_stall_cnt));
    end
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scoreboard bench with a variable-latency memory responder
module tb_unified_mem_arbiter;
  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int lat = 1;
  bit mute = 1'b0;
  exp_t exp_q[$];
  logic [15:0] mem [logic [15:0]];
  unified_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
`ifdef UNIFIED_MEM_ARB_PERF_EN
  logic [15:0] if_stall_cnt, dm_stall_cnt;
`endif
  unified_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef UNIFIED_MEM_ARB_PERF_EN
    ,
    .if_stall_cnt (if_stall_cnt),
    .dm_stall_cnt (dm_stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  // memory responder: acks on the lat-th cycle of a request unless muted
  initial begin
    int req_cycles;
    req_cycles = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!bus.mem_req) begin
        req_cycles = 0;
        bus.mem_ack = 1'b0;
      end else begin
        req_cycles++;
        bus.mem_ack = !mute && req_cycles >= lat;
        if (bus.mem_ack && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        if (bus.mem_ack && !bus.mem_we) bus.mem_rdata = mem[bus.mem_addr];
      end
    end
  end
  // issue monitor: every new memory request must match the oldest expected issue
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL issue: unexpected request addr=%h we=%b", bus.mem_addr, bus.mem_we);
        end else begin
          e = exp_q.pop_front();
          if (bus.mem_addr !== e.addr || bus.mem_we !== e.we || (e.we && bus.mem_wdata !== e.wdata)) begin
            errors++;
            $display("FAIL issue: got addr=%h we=%b wdata=%h, want addr=%h we=%b wdata=%h",
                     bus.mem_addr, bus.mem_we, bus.mem_wdata, e.addr, e.we, e.wdata);
          end
        end
      end
      prev = bus.mem_req;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic test_reset();
    bus.if_re = 0; bus.if_addr = '0; bus.dm_re = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 9;
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    if (bus.mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    if (bus.mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
    if (bus.if_rdata !== 16'h0) begin errors++; $display("FAIL reset_if_rdata: got %h want 0", bus.if_rdata); end
    if (bus.dm_rdata !== 16'h0) begin errors++; $display("FAIL reset_dm_rdata: got %h want 0", bus.dm_rdata); end
    if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    if (bus.if_stall !== 1'b0) begin errors++; $display("FAIL reset_if_stall: got %b want 0", bus.if_stall); end
    if (bus.dm_stall !== 1'b0) begin errors++; $display("FAIL reset_dm_stall: got %b want 0", bus.dm_stall); end
    bus.if_re = 1; bus.dm_we = 1;
    #1;
    checks += 2;
    if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL reset_if_stall_comb: got %b want 1", bus.if_stall); end
    if (bus.dm_stall !== 1'b1) begin errors++; $display("FAIL reset_dm_stall_comb: got %b want 1", bus.dm_stall); end
    bus.if_re = 0; bus.dm_we = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_fetch();
    int n;
    mem[16'h0010] = 16'hB123;
    lat = 2;
    @(negedge clk);
    bus.if_re = 1; bus.if_addr = 16'h0010;
    exp_q.push_back('{16'h0010, 1'b0, 16'h0});
    n = 0;
    repeat (20) begin
      #1;
      if (!bus.if_stall) break;
      n++;
      @(negedge clk);
    end
    checks += 4;
    if (n != 3) begin errors++; $display("FAIL fetch_stall_cycles: got %0d want 3", n); end
    if (bus.if_rdata !== 16'hB123) begin errors++; $display("FAIL fetch_rdata: got %h want b123", bus.if_rdata); end
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL fetch_mem_we: got %b want 0", bus.mem_we); end
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fetch_req_drop: got %b want 0", bus.mem_req); end
    bus.if_re = 0;
  endtask
  task automatic test_arbitration();
    int dc, ic;
    logic [15:0] ird;
    mem[16'h8000] = 16'h0000;
    mem[16'h0020] = 16'hA5A5;
    lat = 1;
    dc = -1; ic = -1; ird = '0;
    @(negedge clk);
    bus.dm_we = 1; bus.dm_addr = 16'h8000; bus.dm_wdata = 16'h00FF;
    bus.if_re = 1; bus.if_addr = 16'h0020;
    exp_q.push_back('{16'h8000, 1'b1, 16'h00FF});
    exp_q.push_back('{16'h0020, 1'b0, 16'h0});
    for (int c = 0; c < 30 && ic < 0; c++) begin
      #1;
      if (dc < 0 && !bus.dm_stall) begin dc = c; bus.dm_we = 0; end
      if (ic < 0 && !bus.if_stall) begin ic = c; ird = bus.if_rdata; bus.if_re = 0; end
      @(negedge clk);
    end
    bus.dm_we = 0; bus.if_re = 0;
    checks += 4;
    if (dc != 2) begin errors++; $display("FAIL arb_store_done: got cycle %0d want 2", dc); end
    if (ic != 5) begin errors++; $display("FAIL arb_fetch_done: got cycle %0d want 5", ic); end
    if (ird !== 16'hA5A5) begin errors++; $display("FAIL arb_fetch_rdata: got %h want a5a5", ird); end
    if (mem[16'h8000] !== 16'h00FF) begin errors++; $display("FAIL arb_store_data: got %h want 00ff", mem[16'h8000]); end
  endtask
  task automatic test_back_to_back();
    int k;
    logic [15:0] ld_data [2];
    mem[16'h9000] = 16'h1111; mem[16'h9002] = 16'h2222; mem[16'h0030] = 16'h3333;
    ld_data[0] = 16'h1111; ld_data[1] = 16'h2222;
    lat = 1;
    k = 0;
    @(negedge clk);
    bus.dm_re = 1; bus.dm_addr = 16'h9000; bus.dm_wdata = '0;
    bus.if_re = 1; bus.if_addr = 16'h0030;
    exp_q.push_back('{16'h9000, 1'b0, 16'h0});
    exp_q.push_back('{16'h0030, 1'b0, 16'h0});
    exp_q.push_back('{16'h9002, 1'b0, 16'h0});
    for (int c = 0; c < 60 && (bus.dm_re || bus.if_re); c++) begin
      #1;
      if (bus.dm_re && !bus.dm_stall) begin
        checks++;
        if (bus.dm_rdata !== ld_data[k]) begin errors++; $display("FAIL b2b_load%0d: got %h want %h", k, bus.dm_rdata, ld_data[k]); end
        k++;
        if (k < 2) bus.dm_addr = 16'h9002;
        else bus.dm_re = 0;
      end
      if (bus.if_re && !bus.if_stall) begin
        checks++;
        if (bus.if_rdata !== 16'h3333) begin errors++; $display("FAIL b2b_fetch: got %h want 3333", bus.if_rdata); end
        bus.if_re = 0;
      end
      @(negedge clk);
    end
    checks++;
    if (k != 2 || bus.if_re) begin errors++; $display("FAIL b2b_complete: loads=%0d fetch_pending=%b want 2,0", k, bus.if_re); end
    bus.dm_re = 0; bus.if_re = 0;
  endtask
  task automatic test_withdraw();
    int n;
    mem[16'h0040] = 16'h1234; mem[16'h0050] = 16'h5555;
    lat = 3;
    @(negedge clk);
    bus.if_re = 1; bus.if_addr = 16'h0040;
    exp_q.push_back('{16'h0040, 1'b0, 16'h0});
    @(negedge clk);
    #1 bus.if_re = 0;
    repeat (3) @(negedge clk);
    #1;
    checks += 2;
    if (bus.if_rdata !== 16'h3333) begin errors++; $display("FAIL withdraw_rdata: got %h want 3333", bus.if_rdata); end
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL withdraw_req: got %b want 0", bus.mem_req); end
    lat = 1;
    bus.if_re = 1; bus.if_addr = 16'h0050;
    exp_q.push_back('{16'h0050, 1'b0, 16'h0});
    #1;
    checks++;
    if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL withdraw_idle: if_stall got %b want 1", bus.if_stall); end
    n = 0;
    repeat (20) begin
      #1;
      if (!bus.if_stall) break;
      n++;
      @(negedge clk);
    end
    checks += 2;
    if (n != 2) begin errors++; $display("FAIL withdraw_next_stall: got %0d want 2", n); end
    if (bus.if_rdata !== 16'h5555) begin errors++; $display("FAIL withdraw_next_rdata: got %h want 5555", bus.if_rdata); end
    bus.if_re = 0;
  endtask
  task automatic test_timeout();
    bit done;
    mem[16'hA000] = 16'h7777;
    mute = 1; lat = 1; done = 0;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL timeout_pre: err got %b want 0", bus.err); end
    bus.dm_re = 1; bus.dm_addr = 16'hA000;
    exp_q.push_back('{16'hA000, 1'b0, 16'h0});
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL timeout_early: err got %b want 0", bus.err); end
    @(negedge clk);
    #1;
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL timeout_set: err got %b want 1", bus.err); end
    mute = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (!bus.dm_stall) begin done = 1; break; end
    end
    checks += 3;
    if (!done) begin errors++; $display("FAIL timeout_ack: dm_stall stuck high"); end
    if (bus.dm_rdata !== 16'h7777) begin errors++; $display("FAIL timeout_rdata: got %h want 7777", bus.dm_rdata); end
    if (bus.err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: err got %b want 1", bus.err); end
    bus.dm_re = 0;
  endtask
  task automatic test_reset_wait();
    mute = 1;
    @(negedge clk);
    bus.dm_re = 1; bus.dm_addr = 16'hB000;
    exp_q.push_back('{16'hB000, 1'b0, 16'h0});
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstwait_req_before: got %b want 1", bus.mem_req); end
    rst = 1'b1;
    #1;
    checks += 5;
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rstwait_req: got %b want 0", bus.mem_req); end
    if (bus.err !== 1'b0) begin errors++; $display("FAIL rstwait_err: got %b want 0", bus.err); end
    if (bus.dm_rdata !== 16'h0) begin errors++; $display("FAIL rstwait_dm_rdata: got %h want 0", bus.dm_rdata); end
    if (bus.if_rdata !== 16'h0) begin errors++; $display("FAIL rstwait_if_rdata: got %h want 0", bus.if_rdata); end
    if (bus.mem_addr !== 16'h0) begin errors++; $display("FAIL rstwait_mem_addr: got %h want 0", bus.mem_addr); end
    @(negedge clk);
    bus.dm_re = 0;
    rst = 1'b0;
    mute = 0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rstwait_idle: mem_req got %b want 0", bus.mem_req); end
  endtask
  initial begin
    test_reset();
    test_fetch();
    test_arbitration();
    test_back_to_back();
    test_withdraw();
    test_timeout();
    test_reset_wait();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d issues outstanding, want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
